// File: rtl/npxl_empfaenger_pkg.sv
// npxl receiver shared types, 48 MHz WS2812 timing constants and helpers.
// Used by both the transmitter and the receiver side of the npxl link.
package npxl_empfaenger_pkg;

  localparam int NPXL_T0H    = 20;
  localparam int NPXL_T1H    = 40;
  localparam int NPXL_TBIT   = 61;
  localparam int NPXL_TLATCH = 3600;

  // Receiver thresholds derived from the nominal line timing
  localparam int NPXL_THRESH = (NPXL_T0H + NPXL_T1H) / 2;
  localparam int NPXL_TMIN   = NPXL_T0H / 2 - 2;
  localparam int NPXL_TMAX   = NPXL_TBIT - 1;
  localparam int NPXL_TRESET = NPXL_TLATCH / 2;

  localparam int CNT_W  = 12;
  localparam int WORD_W = 24;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } state_e;

  function automatic cnt_t sat_inc(cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/npxl_sync.sv
// Two-flop synchronizer for the npxl line plus rise/fall detection.
// All edges refer to the synchronized level.
module npxl_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign o_level = s2;
  assign o_rise  = s2 & ~s3;
  assign o_fall  = ~s2 & s3;

endmodule

// File: rtl/npxl_empfaenger.sv
// WS2812-style serial receiver: decodes pulse widths into 24-bit words
// and emits one write strobe per LED plus a frame-end pulse.
module npxl_empfaenger
  import npxl_empfaenger_pkg::*;
#(
  parameter int LEDS     = 20,
  parameter int ADDR     = 8,
  parameter int T_THRESH = NPXL_THRESH,
  parameter int T_MIN    = NPXL_TMIN,
  parameter int T_MAX    = NPXL_TMAX,
  parameter int T_RESET  = NPXL_TRESET
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_npxl_data,
  output logic              o_wr_en,
  output logic [ADDR-1:0]   o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_frame_done,
  output logic [ADDR-1:0]   o_led_count,
  output logic              o_err,
  output logic              o_overflow
);

  localparam cnt_t C_THR = cnt_t'(T_THRESH);
  localparam cnt_t C_MIN = cnt_t'(T_MIN);
  localparam cnt_t C_MAX = cnt_t'(T_MAX);
  localparam cnt_t C_GAP = cnt_t'(T_RESET - 1);

  localparam logic [ADDR-1:0] A_MAX = ADDR'(LEDS);
  localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

  logic line;
  logic rise;
  logic fall;

  npxl_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_npxl_data),
    .o_level (line),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  state_e state;
  state_e state_n;

  cnt_t cnt;
  cnt_t gap;
  cnt_t ht;

  logic [4:0]        bitcnt;
  logic [WORD_W-2:0] shreg;
  logic [WORD_W-1:0] word_n;
  logic [ADDR-1:0]   addr;

  logic gap_hit;
  logic bad_w;
  logic bit_v;
  logic start;
  logic new_frame;
  logic take_bit;
  logic bad;
  logic done;
  logic resync;

  // cnt lags the true high time by one: the rise cycle is not counted
  assign ht      = sat_inc(cnt);
  assign bit_v   = ht >= C_THR;
  assign bad_w   = (ht < C_MIN) || (ht > C_MAX);
  assign gap_hit = !line && (gap == C_GAP);
  assign word_n  = {shreg, bit_v};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= SYNC;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    start     = 1'b0;
    new_frame = 1'b0;
    take_bit  = 1'b0;
    bad       = 1'b0;
    done      = 1'b0;
    resync    = 1'b0;
    unique case (state)
      SYNC: begin
        if (gap_hit) begin
          state_n = IDLE;
          resync  = 1'b1;
        end
      end
      IDLE, LOW: begin
        if (rise) begin
          state_n   = HIGH;
          start     = 1'b1;
          new_frame = (state == IDLE);
        end else if (gap_hit) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      HIGH: begin
        unique case (1'b1)
          fall && bad_w: begin
            state_n = SYNC;
            bad     = 1'b1;
          end
          fall && !bad_w: begin
            state_n  = LOW;
            take_bit = 1'b1;
          end
          line && (cnt >= C_MAX): begin
            state_n = SYNC;
            bad     = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt          <= '0;
      gap          <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      addr         <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_led_count  <= '0;
      o_err        <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      gap          <= line ? '0 : sat_inc(gap);

      if (start) begin
        cnt <= '0;
      end else if (state == HIGH && line) begin
        cnt <= sat_inc(cnt);
      end

      if (new_frame) begin
        o_err      <= 1'b0;
        o_overflow <= 1'b0;
      end

      if (take_bit) begin
        shreg <= word_n[WORD_W-2:0];
        if (bitcnt == LAST_BIT) begin
          bitcnt <= '0;
          if (addr >= A_MAX) begin
            o_overflow <= 1'b1;
          end else begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= addr;
            o_wr_data <= word_n;
            addr      <= addr + ADDR'(1);
          end
        end else begin
          bitcnt <= bitcnt + 5'd1;
        end
      end

      if (bad) begin
        o_err  <= 1'b1;
        bitcnt <= '0;
        addr   <= '0;
      end

      if (done) begin
        o_frame_done <= 1'b1;
        o_led_count  <= (addr > A_MAX) ? A_MAX : addr;
        if (bitcnt != '0) begin
          o_err <= 1'b1;
        end
        addr   <= '0;
        bitcnt <= '0;
      end

      // Leaving SYNC restarts the gap count so IDLE sees a full latch gap
      if (resync) begin
        gap    <= '0;
        addr   <= '0;
        bitcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_npxl_empfaenger.sv
// Self-checking bench for npxl_empfaenger: directed frames, queue model
// of expected writes and frame ends, plus literal pins per scenario.
module tb_npxl_empfaenger;

  localparam int LEDS = 20;
  localparam int ADDR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;

  logic            wr_en;
  logic [ADDR-1:0] wr_addr;
  logic [23:0]     wr_data;
  logic            frame_done;
  logic [ADDR-1:0] led_count;
  logic            err;
  logic            ovf;

  always #10 clk = ~clk;

  npxl_empfaenger #(
    .LEDS (LEDS),
    .ADDR (ADDR)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_npxl_data  (din),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_frame_done (frame_done),
    .o_led_count  (led_count),
    .o_err        (err),
    .o_overflow   (ovf)
  );

  int errors = 0;
  int checks = 0;

  int          q_addr[$];
  logic [23:0] q_data[$];
  int          q_cnt[$];
  int          q_err[$];
  int          q_ovf[$];

  int          n_wr = 0;
  int          n_done = 0;
  int          last_addr = -1;
  logic [23:0] last_data = '0;
  int          last_cnt = -1;
  int          last_err = -1;
  int          last_ovf = -1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      n_wr++;
      last_addr = int'(wr_addr);
      last_data = wr_data;
      chk("write_pending", 32'(q_addr.size() > 0), 1);
      if (q_addr.size() > 0) begin
        chk("wr_addr", 32'(wr_addr), 32'(q_addr.pop_front()));
        chk("wr_data", 32'(wr_data), 32'(q_data.pop_front()));
      end
    end
    if (frame_done) begin
      n_done++;
      last_cnt = int'(led_count);
      last_err = int'(err);
      last_ovf = int'(ovf);
      chk("done_pending", 32'(q_cnt.size() > 0), 1);
      if (q_cnt.size() > 0) begin
        chk("led_count", 32'(led_count), 32'(q_cnt.pop_front()));
        chk("done_err", 32'(err), 32'(q_err.pop_front()));
        chk("done_ovf", 32'(ovf), 32'(q_ovf.pop_front()));
      end
    end
  end

  function automatic logic [23:0] pat(input int k);
    return 24'(32'hFF0055 + 32'(k) * 32'h0135A7);
  endfunction

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int lo);
    din = 1'b1;
    repeat (h) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit fast);
    int h;
    h = b ? 40 : 20;
    pulse(h, fast ? 10 : 61 - h);
  endtask

  task automatic send_word(input logic [23:0] w, input bit fast);
    for (int i = 23; i >= 0; i--) send_bit(w[i], fast);
  endtask

  // Expected behaviour: first LEDS words written in order, rest dropped
  task automatic frame(input int nw, input int extra, input bit fast);
    for (int k = 0; k < nw; k++) begin
      if (k < LEDS) begin
        q_addr.push_back(k);
        q_data.push_back(pat(k));
      end
      send_word(pat(k), fast);
    end
    for (int i = 0; i < extra; i++) send_bit(logic'(i % 2), fast);
    q_cnt.push_back(nw < LEDS ? nw : LEDS);
    q_err.push_back(extra != 0 ? 1 : 0);
    q_ovf.push_back(nw > LEDS ? 1 : 0);
    idle(3600);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_count"}, 32'(led_count), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    int w0;
    int d0;

    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    idle(1900);

    w0 = n_wr;
    frame(1, 0, 1'b0);
    chk("single_writes", 32'(n_wr - w0), 1);
    chk("single_addr", 32'(last_addr), 0);
    chk("single_data", 32'(last_data), 32'h00FF0055);
    chk("single_count", 32'(last_cnt), 1);

    w0 = n_wr;
    frame(20, 0, 1'b1);
    chk("full_writes", 32'(n_wr - w0), 20);
    chk("full_last_addr", 32'(last_addr), 19);
    chk("full_count", 32'(last_cnt), 20);
    chk("full_ovf", 32'(last_ovf), 0);

    w0 = n_wr;
    frame(22, 0, 1'b1);
    chk("over_writes", 32'(n_wr - w0), 20);
    chk("over_count", 32'(last_cnt), 20);
    chk("over_ovf", 32'(last_ovf), 1);

    // Glitch mid-word: earlier word kept, partial dropped, no frame end
    w0 = n_wr;
    d0 = n_done;
    q_addr.push_back(0);
    q_data.push_back(pat(0));
    send_word(pat(0), 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    pulse(4, 0);
    idle(2500);
    chk("glitch_err", 32'(err), 1);
    chk("glitch_writes", 32'(n_wr - w0), 1);
    chk("glitch_no_done", 32'(n_done - d0), 0);

    frame(2, 0, 1'b0);
    chk("recover_err", 32'(last_err), 0);
    chk("recover_count", 32'(last_cnt), 2);

    // Line stuck high past the error limit
    d0 = n_done;
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    pulse(70, 0);
    idle(2500);
    chk("stuck_err", 32'(err), 1);
    chk("stuck_no_done", 32'(n_done - d0), 0);
    frame(1, 0, 1'b0);

    w0 = n_wr;
    frame(0, 12, 1'b0);
    chk("partial_writes", 32'(n_wr - w0), 0);
    chk("partial_count", 32'(last_cnt), 0);
    chk("partial_err", 32'(last_err), 1);
    frame(1, 0, 1'b0);
    chk("after_partial_err", 32'(last_err), 0);

    // Reset in the middle of a word
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("midreset");
    rst_n = 1'b1;
    idle(1900);
    frame(1, 0, 1'b0);
    chk("midreset_addr", 32'(last_addr), 0);
    chk("midreset_data", 32'(last_data), 32'(pat(0)));

    // Empty frame: resync then one full latch gap in IDLE
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done;
    q_cnt.push_back(0);
    q_err.push_back(0);
    q_ovf.push_back(0);
    idle(4000);
    chk("empty_done", 32'(n_done - d0), 1);
    chk("empty_count", 32'(last_cnt), 0);

    chk("writes_outstanding", 32'(q_addr.size()), 0);
    chk("done_outstanding", 32'(q_cnt.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
